// File: rtl/palette_access_ctrl_if.sv
// Signal bundle between the palette port-A controller, its two requesters
// (host register bus, fill engine control) and palette RAM port A.
interface palette_access_ctrl_if #(
   parameter int NUM_CHANNELS = 3,
   parameter int ADDR_WIDTH   = 10
);
   localparam int DATA_WIDTH = 8 * NUM_CHANNELS;

   logic                    host_req;
   logic                    host_wr;
   logic [ADDR_WIDTH-1:0]   host_addr;
   logic [DATA_WIDTH-1:0]   host_wdata;
   logic [NUM_CHANNELS-1:0] host_byte_en;
   logic [DATA_WIDTH-1:0]   host_rdata;
   logic                    host_ack;

   logic                    fill_start;
   logic [ADDR_WIDTH-1:0]   fill_base;
   logic [ADDR_WIDTH:0]     fill_count;
   logic [DATA_WIDTH-1:0]   fill_color;
   logic                    fill_busy;
   logic                    fill_done;

   logic                    pal_wr;
   logic                    pal_rd;
   logic [ADDR_WIDTH-1:0]   pal_addr;
   logic [DATA_WIDTH-1:0]   pal_wdata;
   logic [NUM_CHANNELS-1:0] pal_byte_en;
   logic [DATA_WIDTH-1:0]   pal_rdata;

   modport slave (
      input  host_req, host_wr, host_addr, host_wdata, host_byte_en,
      output host_rdata, host_ack,
      input  fill_start, fill_base, fill_count, fill_color,
      output fill_busy, fill_done,
      output pal_wr, pal_rd, pal_addr, pal_wdata, pal_byte_en,
      input  pal_rdata
   );

   modport master (
      output host_req, host_wr, host_addr, host_wdata, host_byte_en,
      input  host_rdata, host_ack,
      output fill_start, fill_base, fill_count, fill_color,
      input  fill_busy, fill_done,
      input  pal_wr, pal_rd, pal_addr, pal_wdata, pal_byte_en,
      output pal_rdata
   );
endinterface

// File: rtl/palette_access_ctrl.sv
// Shares palette RAM port A between host single accesses and a run-fill engine.
// Host wins contention unless it was granted last; all port-A outputs are registered.
module palette_access_ctrl #(
   parameter int NUM_CHANNELS = 3,
   parameter int ADDR_WIDTH   = 10
) (
   input logic                  clk,
   input logic                  reset,
   palette_access_ctrl_if.slave bus
);
   localparam int NCH = NUM_CHANNELS;
   localparam int AW  = ADDR_WIDTH;
   localparam int DW  = 8 * NUM_CHANNELS;

   typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_e;

   fill_state_e    fill_state_q, fill_state_d;
   logic [AW-1:0]  cursor_q, cursor_d;
   logic [AW:0]    remain_q, remain_d;
   logic [DW-1:0]  color_q, color_d;
   logic           fill_done_q, fill_done_d;
   logic           last_host_q, last_host_d;
   logic           rd_cap_q, rd_cap_d;
   logic           host_ack_q, host_ack_d;
   logic [DW-1:0]  host_rdata_q, host_rdata_d;
   logic           pal_wr_q, pal_wr_d;
   logic           pal_rd_q, pal_rd_d;
   logic [AW-1:0]  pal_addr_q, pal_addr_d;
   logic [DW-1:0]  pal_wdata_q, pal_wdata_d;
   logic [NCH-1:0] pal_byte_en_q, pal_byte_en_d;

   logic host_pend, fill_pend, grant_host, grant_fill;

   // A host op in flight (read pipeline or ack cycle) masks the held host_req.
   assign host_pend  = bus.host_req & ~pal_rd_q & ~rd_cap_q & ~host_ack_q;
   assign fill_pend  = (fill_state_q == FILL_RUN);
   assign grant_host = host_pend & ~(fill_pend & last_host_q);
   assign grant_fill = fill_pend & ~grant_host;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latches are inferred.
      fill_state_d  = fill_state_q;
      cursor_d      = cursor_q;
      remain_d      = remain_q;
      color_d       = color_q;
      fill_done_d   = 1'b0;
      last_host_d   = last_host_q;
      rd_cap_d      = pal_rd_q;
      host_ack_d    = rd_cap_q;
      host_rdata_d  = rd_cap_q ? bus.pal_rdata : host_rdata_q;
      pal_wr_d      = 1'b0;
      pal_rd_d      = 1'b0;
      pal_byte_en_d = '0;
      pal_addr_d    = pal_addr_q;
      pal_wdata_d   = pal_wdata_q;

      unique case (fill_state_q)
         FILL_IDLE: begin
            if (bus.fill_start) begin
               if (bus.fill_count != '0) begin
                  fill_state_d = FILL_RUN;
                  cursor_d     = bus.fill_base;
                  remain_d     = bus.fill_count;
                  color_d      = bus.fill_color;
               end else begin
                  fill_done_d  = 1'b1;
               end
            end
         end
         FILL_RUN: begin
            if (grant_fill) begin
               pal_wr_d      = 1'b1;
               pal_byte_en_d = '1;
               pal_addr_d    = cursor_q;
               pal_wdata_d   = color_q;
               cursor_d      = cursor_q + AW'(1);
               remain_d      = remain_q - (AW+1)'(1);
               last_host_d   = 1'b0;
               if (remain_q == (AW+1)'(1)) begin
                  fill_state_d = FILL_IDLE;
                  fill_done_d  = 1'b1;
               end
            end
         end
         default: fill_state_d = FILL_IDLE;
      endcase

      if (grant_host) begin
         last_host_d = 1'b1;
         pal_addr_d  = bus.host_addr;
         if (bus.host_wr) begin
            pal_wr_d      = 1'b1;
            pal_byte_en_d = bus.host_byte_en;
            pal_wdata_d   = bus.host_wdata;
            host_ack_d    = 1'b1;
         end else begin
            pal_rd_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         fill_state_q  <= FILL_IDLE;
         cursor_q      <= '0;
         remain_q      <= '0;
         color_q       <= '0;
         fill_done_q   <= 1'b0;
         last_host_q   <= 1'b0;
         rd_cap_q      <= 1'b0;
         host_ack_q    <= 1'b0;
         host_rdata_q  <= '0;
         pal_wr_q      <= 1'b0;
         pal_rd_q      <= 1'b0;
         pal_addr_q    <= '0;
         pal_wdata_q   <= '0;
         pal_byte_en_q <= '0;
      end else begin
         fill_state_q  <= fill_state_d;
         cursor_q      <= cursor_d;
         remain_q      <= remain_d;
         color_q       <= color_d;
         fill_done_q   <= fill_done_d;
         last_host_q   <= last_host_d;
         rd_cap_q      <= rd_cap_d;
         host_ack_q    <= host_ack_d;
         host_rdata_q  <= host_rdata_d;
         pal_wr_q      <= pal_wr_d;
         pal_rd_q      <= pal_rd_d;
         pal_addr_q    <= pal_addr_d;
         pal_wdata_q   <= pal_wdata_d;
         pal_byte_en_q <= pal_byte_en_d;
      end
   end

   assign bus.host_rdata  = host_rdata_q;
   assign bus.host_ack    = host_ack_q;
   assign bus.fill_busy   = fill_pend;
   assign bus.fill_done   = fill_done_q;
   assign bus.pal_wr      = pal_wr_q;
   assign bus.pal_rd      = pal_rd_q;
   assign bus.pal_addr    = pal_addr_q;
   assign bus.pal_wdata   = pal_wdata_q;
   assign bus.pal_byte_en = pal_byte_en_q;
endmodule

// File: tb/tb_palette_access_ctrl.sv
// Scoreboard bench for palette_access_ctrl: stimulus pushes expected port-A ops,
// acks and done pulses; a forked monitor pops and compares as the DUT presents them.
module tb_palette_access_ctrl;
   localparam int NCH   = 3;
   localparam int AW    = 10;
   localparam int DW    = 24;
   localparam int DEPTH = 1024;

   typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; logic last; } fill_exp_t;
   typedef struct { int cyc; logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [NCH-1:0] be; } host_exp_t;
   typedef struct { int cyc; logic rd; logic [DW-1:0] rdata; } ack_exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   fill_seen = 0;
   int   fill_wr_cnt [DEPTH];
   logic [DW-1:0] mem [DEPTH];

   fill_exp_t exp_fill[$];
   host_exp_t exp_host[$];
   ack_exp_t  exp_ack[$];
   int        exp_zdone[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   palette_access_ctrl_if #(.NUM_CHANNELS(NCH), .ADDR_WIDTH(AW)) bus ();

   palette_access_ctrl #(.NUM_CHANNELS(NCH), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [DW-1:0] pre(input int i);
      logic [AW-1:0] a;
      a = AW'(i);
      if (i == 7) return 24'hA1B2C3;
      return {8'h5A, 6'b0, a};
   endfunction

   // Palette RAM port A: registered read, byte-enabled write, preloaded during reset.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= pre(i);
         bus.pal_rdata <= '0;
      end else begin
         if (bus.pal_rd) bus.pal_rdata <= mem[bus.pal_addr];
         if (bus.pal_wr)
            for (int b = 0; b < NCH; b++)
               if (bus.pal_byte_en[b]) mem[bus.pal_addr][8*b +: 8] <= bus.pal_wdata[8*b +: 8];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor_step();
      fill_exp_t mf;
      host_exp_t mh;
      ack_exp_t  ma;
      int        zc;
      logic      is_fill;
      is_fill = bus.pal_wr && (bus.pal_byte_en == 3'b111);
      if (is_fill) begin
         check("fill_unexpected_wr", exp_fill.size() > 0, 1);
         if (exp_fill.size() > 0) begin
            mf = exp_fill.pop_front();
            check("fill_addr", bus.pal_addr, mf.addr);
            check("fill_data", bus.pal_wdata, mf.data);
            check("fill_done_with_last", bus.fill_done, mf.last);
            if (mf.last) check("fill_busy_at_last", bus.fill_busy, 0);
            if (mf.cyc >= 0) check("fill_cycle", cyc, mf.cyc);
         end
         fill_seen++;
         fill_wr_cnt[bus.pal_addr]++;
      end else if (bus.pal_wr || bus.pal_rd) begin
         check("host_unexpected_op", exp_host.size() > 0, 1);
         if (exp_host.size() > 0) begin
            mh = exp_host.pop_front();
            check("host_op_kind", {bus.pal_wr, bus.pal_rd}, {mh.wr, ~mh.wr});
            check("host_pal_addr", bus.pal_addr, mh.addr);
            check("host_pal_be", bus.pal_byte_en, mh.be);
            if (mh.wr) check("host_pal_wdata", bus.pal_wdata, mh.data);
            check("host_pal_cycle", cyc, mh.cyc);
         end
      end
      if (bus.fill_done && !is_fill) begin
         check("fill_done_unexpected", exp_zdone.size() > 0, 1);
         if (exp_zdone.size() > 0) begin
            zc = exp_zdone.pop_front();
            check("zero_fill_done_cycle", cyc, zc);
         end
      end
      if (bus.host_ack) begin
         check("host_ack_unexpected", exp_ack.size() > 0, 1);
         if (exp_ack.size() > 0) begin
            ma = exp_ack.pop_front();
            check("host_ack_cycle", cyc, ma.cyc);
            if (ma.rd) check("host_rdata", bus.host_rdata, ma.rdata);
         end
      end
   endtask

   // b2b: request is raised in the previous op's ack cycle, so it is seen one cycle later.
   task automatic host_op(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [NCH-1:0] be, input logic [DW-1:0] rdata, input bit b2b);
      host_exp_t h;
      ack_exp_t  a;
      bit        got;
      bus.host_req     = 1'b1;
      bus.host_wr      = wr;
      bus.host_addr    = addr;
      bus.host_wdata   = data;
      bus.host_byte_en = be;
      h.cyc  = cyc + (b2b ? 2 : 1);
      h.wr   = wr;
      h.addr = addr;
      h.data = data;
      h.be   = wr ? be : '0;
      exp_host.push_back(h);
      a.cyc   = wr ? h.cyc : h.cyc + 2;
      a.rd    = ~wr;
      a.rdata = rdata;
      exp_ack.push_back(a);
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = bus.host_ack;
      end
      check("host_ack_timeout", got, 1);
   endtask

   task automatic host_idle();
      bus.host_req = 1'b0;
      bus.host_wr  = 1'b0;
   endtask

   task automatic fill_op(input logic [AW-1:0] base, input logic [AW:0] count,
                          input logic [DW-1:0] color, input bit timed, input bit accept);
      fill_exp_t f;
      bus.fill_start = 1'b1;
      bus.fill_base  = base;
      bus.fill_count = count;
      bus.fill_color = color;
      if (accept) begin
         if (count == '0) exp_zdone.push_back(cyc + 1);
         for (int k = 0; k < int'(count); k++) begin
            f.cyc  = timed ? cyc + 2 + k : -1;
            f.addr = AW'(int'(base) + k);
            f.data = color;
            f.last = (k == int'(count) - 1);
            exp_fill.push_back(f);
         end
      end
      @(negedge clk);
      bus.fill_start = 1'b0;
   endtask

   task automatic wait_fill_drain(input int budget);
      for (int i = 0; i < budget && exp_fill.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check("fill_drain", exp_fill.size(), 0);
   endtask

   initial begin
      int snap [DEPTH];
      int s0;
      int n_bad;
      bit got;
      reset            = 1'b1;
      bus.host_req     = 1'b0;
      bus.host_wr      = 1'b0;
      bus.host_addr    = '0;
      bus.host_wdata   = '0;
      bus.host_byte_en = '0;
      bus.fill_start   = 1'b0;
      bus.fill_base    = '0;
      bus.fill_count   = '0;
      bus.fill_color   = '0;
      for (int i = 0; i < DEPTH; i++) fill_wr_cnt[i] = 0;
      fork
         forever begin
            @(negedge clk);
            #1;
            monitor_step();
         end
      join_none

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_pal_wr", bus.pal_wr, 0);
      check("rst_pal_rd", bus.pal_rd, 0);
      check("rst_pal_addr", bus.pal_addr, 0);
      check("rst_pal_wdata", bus.pal_wdata, 0);
      check("rst_pal_be", bus.pal_byte_en, 0);
      check("rst_host_ack", bus.host_ack, 0);
      check("rst_host_rdata", bus.host_rdata, 0);
      check("rst_fill_busy", bus.fill_busy, 0);
      check("rst_fill_done", bus.fill_done, 0);

      // Host write with partial byte enables, then reads back.
      host_op(1'b1, 10'd5, 24'h123456, 3'b101, '0, 1'b0);
      host_idle();
      @(negedge clk);
      host_op(1'b0, 10'd7, '0, '0, 24'hA1B2C3, 1'b0);
      host_idle();
      @(negedge clk);
      host_op(1'b0, 10'd5, '0, '0, 24'h120056, 1'b0);
      host_idle();
      repeat (3) @(negedge clk);
      check("host_rdata_hold", bus.host_rdata, 24'h120056);

      // Fill that wraps past the top of the palette.
      fill_op(10'd1020, 11'd8, 24'h00FF00, 1'b1, 1'b1);
      check("fill_busy_after_start", bus.fill_busy, 1);
      wait_fill_drain(40);
      check("mem4_intact", mem[4], pre(4));
      check("mem1019_intact", mem[1019], pre(1019));
      check("mem1023_filled", mem[1023], 24'h00FF00);
      check("mem3_filled", mem[3], 24'h00FF00);

      // fill_start while busy is ignored; count 0 gives a lone done pulse.
      fill_op(10'd100, 11'd4, 24'h111111, 1'b1, 1'b1);
      fill_op(10'd200, 11'd5, 24'h222222, 1'b0, 1'b0);
      wait_fill_drain(40);
      check("ignored_fill_mem200", mem[200], pre(200));
      repeat (2) @(negedge clk);
      fill_op(10'd300, 11'd0, 24'h333333, 1'b1, 1'b1);
      check("zero_fill_not_busy", bus.fill_busy, 0);
      repeat (3) @(negedge clk);

      // Full-palette fill while the host writes back-to-back.
      for (int i = 0; i < DEPTH; i++) snap[i] = fill_wr_cnt[i];
      fork
         fill_op(10'd512, 11'd1024, 24'h0A0B0C, 1'b0, 1'b1);
         begin
            for (int i = 0; i < 40; i++)
               host_op(1'b1, AW'(768 + i), DW'(24'hB00000 + i), 3'b011, '0, i != 0);
            host_idle();
         end
      join
      wait_fill_drain(3000);
      n_bad = 0;
      for (int i = 0; i < DEPTH; i++) if (fill_wr_cnt[i] - snap[i] != 1) n_bad++;
      check("fill1024_every_addr_once", n_bad, 0);
      check("fill1024_host_acks_drained", exp_ack.size(), 0);

      // Reset in the middle of a fill, then a fresh fill.
      repeat (2) @(negedge clk);
      s0 = fill_seen;
      fill_op(10'd0, 11'd10, 24'h777777, 1'b0, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         if (fill_seen >= s0 + 3) got = 1'b1;
         else @(negedge clk);
      end
      check("midfill_three_writes_seen", got, 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_pal_wr", bus.pal_wr, 0);
      check("midrst_pal_rd", bus.pal_rd, 0);
      check("midrst_pal_addr", bus.pal_addr, 0);
      check("midrst_pal_wdata", bus.pal_wdata, 0);
      check("midrst_pal_be", bus.pal_byte_en, 0);
      check("midrst_fill_busy", bus.fill_busy, 0);
      check("midrst_fill_done", bus.fill_done, 0);
      check("midrst_host_ack", bus.host_ack, 0);
      exp_fill.delete();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("postrst_fill_busy", bus.fill_busy, 0);
      fill_op(10'd50, 11'd3, 24'h0F0F0F, 1'b1, 1'b1);
      wait_fill_drain(40);
      check("postrst_mem51", mem[51], 24'h0F0F0F);
      check("postrst_mem53_intact", mem[53], pre(53));

      repeat (5) @(negedge clk);
      check("host_ops_drained", exp_host.size(), 0);
      check("host_acks_drained", exp_ack.size(), 0);
      check("zero_dones_drained", exp_zdone.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
